// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_slice.sv
// One-bit full adder composed of two half-adder cells and an OR of their carries.
module full_adder_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  halfAdder u_ha0 (
    .a(a),
    .b(b),
    .s(s1),
    .c(c1)
  );

  halfAdder u_ha1 (
    .a(s1),
    .b(ci),
    .s(s),
    .c(c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/halfAdder.sv
// Single-bit half-adder cell shared across the datapath library.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: start/done handshake around one full-adder slice,
// operands shifted LSB-first, running carry held in a flop.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             slice_s;
  logic             slice_co;
  logic             last_bit;

  full_adder_slice u_slice (
    .a (sh_a[0]),
    .b (sh_b[0]),
    .ci(carry),
    .s (slice_s),
    .co(slice_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // New slice bit enters at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = slice_s;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end
        end
        S_RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= slice_co;
          sum   <= sum_shift;
          cnt   <= cnt + CW'(1);
          if (last_bit) cout <= slice_co;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [8:0]  val;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned passed = 0;
  int unsigned total = 0;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  exp_t sb8[$];
  exp_t sb2[$];
  exp_t e8;
  exp_t e2;
  logic prev_done2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      check("done8_busy_low", 64'(busy8), 64'(0));
      if (sb8.size() == 0) check("done8_expected", 64'(0), 64'(1));
      else begin
        e8 = sb8.pop_front();
        check("sum8", 64'({cout8, sum8}), 64'(e8.val));
        check("done8_cycle", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      check("done2_busy_low", 64'(busy2), 64'(0));
      check("done2_one_cycle", 64'(prev_done2), 64'(0));
      if (sb2.size() == 0) check("done2_expected", 64'(0), 64'(1));
      else begin
        e2 = sb2.pop_front();
        check("sum2", 64'({cout2, sum2}), 64'(e2.val));
        check("done2_cycle", 64'(cyc), 64'(e2.cyc));
      end
    end
    prev_done2 = (done2 === 1'b1);
  end

  task automatic drain8(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (sb8.size() == 0) break;
      @(negedge clk); #2;
    end
    check("drain8", 64'(sb8.size()), 64'(0));
  endtask

  task automatic drain2(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (sb2.size() == 0) break;
      @(negedge clk); #2;
    end
    check("drain2", 64'(sb2.size()), 64'(0));
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned k;
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb8.push_back('{val: 9'(x) + 9'(y) + 9'(c), cyc: k + 8});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check("busy8_after_start", 64'(busy8), 64'(1));
    drain8(20);
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int unsigned k;
    @(negedge clk);
    a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb2.push_back('{val: 9'(x) + 9'(y) + 9'(c), cyc: k + 2});
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    check("busy2_after_start", 64'(busy2), 64'(1));
    drain2(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy8", 64'(busy8), 64'(0));
      check("rst_done8", 64'(done8), 64'(0));
      check("rst_sum8", 64'({cout8, sum8}), 64'(0));
      check("rst_busy2", 64'(busy2), 64'(0));
      check("rst_sum2", 64'({done2, cout2, sum2}), 64'(0));
    end
    rst = 1'b0; start8 = 1'b0; start2 = 1'b0;

    op8(8'h3C, 8'h0F, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1);

    // start held high, operands changed mid-run
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb8.push_back('{val: 9'h030, cyc: k + 8});
    sb8.push_back('{val: 9'h1FE, cyc: k + 18});
    while (cyc < k + 3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    while (cyc < k + 10) @(negedge clk);
    start8 = 1'b0;
    drain8(30);

    // reset in the middle of a run
    @(negedge clk);
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc < k + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy8", 64'(busy8), 64'(0));
    check("abort_done8", 64'(done8), 64'(0));
    check("abort_sum8", 64'({cout8, sum8}), 64'(0));
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb8.push_back('{val: 9'h002, cyc: k + 8});
    @(negedge clk);
    start8 = 1'b0;
    drain8(20);

    for (int i = 0; i < 16; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int unsigned n = 0; n < 32; n++) begin
      logic [4:0] v;
      v = 5'(n);
      op2(v[4:3], v[2:1], v[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
